video_timing_detect: RTL and testbench

Receive-side counterpart of the team's colour-bar/test-pattern timing generator: accepts a raw hs/vs/de/RGB stream, normalises sync polarity, measures horizontal and vertical timing, and locks once consecutive frames agree. Sits at the front of the scaler input path. It forwards the pixel stream with active-area x/y coordinates and start-of-frame/end-of-line markers, and reports the locked format to the scaler control logic.

---
 rtl/video_timing_detect.sv | 210 +++++++++++++++++++++
 tb/tb_video_timing_detect.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/video_timing_detect.sv
// Receive-side video timing detector: normalises sync polarity, measures H/V timing,
// locks once consecutive frames agree, and forwards the pixel stream with coordinates.
module video_timing_detect #(
  parameter bit HS_POLORY   = 1'b1,
  parameter bit VS_POLORY   = 1'b1,
  parameter int CNT_W       = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic [7:0]       i_r,
  input  logic [7:0]       i_g,
  input  logic [7:0]       i_b,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [7:0]       o_r,
  output logic [7:0]       o_g,
  output logic [7:0]       o_b,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_sof,
  output logic             o_eol,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_h_active,
  output logic [CNT_W-1:0] o_v_total,
  output logic [CNT_W-1:0] o_v_active,
  output logic             o_locked,
  output logic             o_err
);

  localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_SEEK, ST_ACQ, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic             ref_valid_q, ref_valid_d;
  logic [4*CNT_W-1:0] ref_q, ref_d, tuple;
  logic [4*CNT_W-1:0] pub_q, pub_d;
  logic             locked_q, locked_d, err_q, err_d;

  logic       s_hs_q, s_hs_d, s_vs_q, s_vs_d, s_de_q, s_de_d;
  logic [7:0] s_r_q, s_r_d, s_g_q, s_g_d, s_b_q, s_b_d;
  logic       hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, de_dly_q, de_dly_d;
  logic       hs_rise, vs_rise, de_fall;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, h_cnt_inc, de_len_q, de_len_d;
  logic [CNT_W-1:0] v_line_q, v_line_d, act_lines_q, act_lines_d;
  logic [CNT_W-1:0] meas_h_total_q, meas_h_total_d, meas_h_active_q, meas_h_active_d;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;

  logic       o_hs_q, o_hs_d, o_vs_q, o_vs_d, o_de_q, o_de_d;
  logic [7:0] o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
  logic [CNT_W-1:0] o_x_q, o_x_d, o_y_q, o_y_d;
  logic       o_sof_q, o_sof_d, o_eol_q, o_eol_d;

  assign hs_rise = s_hs_q & ~hs_dly_q;
  assign vs_rise = s_vs_q & ~vs_dly_q;
  assign de_fall = ~s_de_q & de_dly_q;
  assign h_cnt_inc = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 1'b1;
  assign tuple = {meas_h_total_q, meas_h_active_q, v_line_q, act_lines_q};

  always_comb begin
    s_hs_d   = HS_POLORY ? i_hs : ~i_hs;
    s_vs_d   = VS_POLORY ? i_vs : ~i_vs;
    s_de_d   = i_de;
    s_r_d    = i_r;
    s_g_d    = i_g;
    s_b_d    = i_b;
    hs_dly_d = s_hs_q;
    vs_dly_d = s_vs_q;
    de_dly_d = s_de_q;

    h_cnt_d         = h_cnt_inc;
    meas_h_total_d  = meas_h_total_q;
    de_len_d        = de_len_q;
    meas_h_active_d = meas_h_active_q;
    v_line_d        = v_line_q;
    act_lines_d     = act_lines_q;
    x_cnt_d         = x_cnt_q;
    y_cnt_d         = y_cnt_q;

    if (hs_rise) begin
      meas_h_total_d = h_cnt_inc;
      h_cnt_d        = '0;
      if (v_line_q != CNT_MAX) v_line_d = v_line_q + 1'b1;
    end
    if (s_de_q && de_len_q != CNT_MAX) de_len_d = de_len_q + 1'b1;
    if (s_de_q) x_cnt_d = x_cnt_q + 1'b1;
    if (de_fall) begin
      meas_h_active_d = de_len_q;
      de_len_d        = '0;
      x_cnt_d         = '0;
      y_cnt_d         = y_cnt_q + 1'b1;
      if (act_lines_q != CNT_MAX) act_lines_d = act_lines_q + 1'b1;
    end
    // a sync edge coincident with vs belongs to the new frame
    if (vs_rise) begin
      v_line_d    = CNT_W'(hs_rise);
      act_lines_d = '0;
      y_cnt_d     = '0;
    end

    o_hs_d  = s_hs_q;
    o_vs_d  = s_vs_q;
    o_de_d  = s_de_q;
    o_r_d   = s_r_q;
    o_g_d   = s_g_q;
    o_b_d   = s_b_q;
    o_x_d   = s_de_q ? x_cnt_q : '0;
    o_y_d   = s_de_q ? y_cnt_q : '0;
    o_sof_d = s_de_q && (x_cnt_q == '0) && (y_cnt_q == '0);
    o_eol_d = locked_q && s_de_q && (x_cnt_q == pub_q[3*CNT_W-1:2*CNT_W] - 1'b1);
  end

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    ref_valid_d = ref_valid_q;
    ref_d       = ref_q;
    pub_d       = pub_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    if (vs_rise) begin
      case (state_q)
        ST_SEEK: begin
          state_d     = ST_ACQ;
          match_d     = '0;
          ref_valid_d = 1'b0;
        end
        ST_ACQ: begin
          ref_d       = tuple;
          ref_valid_d = 1'b1;
          if (ref_valid_q && tuple == ref_q && act_lines_q != '0) begin
            match_d = match_q + 1'b1;
            if (match_d == MW'(LOCK_FRAMES)) begin
              state_d  = ST_LOCKED;
              pub_d    = tuple;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          if (tuple != ref_q || act_lines_q == '0) begin
            err_d       = 1'b1;
            locked_d    = 1'b0;
            state_d     = ST_ACQ;
            ref_d       = tuple;
            ref_valid_d = 1'b1;
            match_d     = '0;
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEEK;   match_q <= '0;  ref_valid_q <= 1'b0;
      ref_q <= '0;          pub_q <= '0;    locked_q <= 1'b0;  err_q <= 1'b0;
      s_hs_q <= 1'b0;       s_vs_q <= 1'b0; s_de_q <= 1'b0;
      s_r_q <= '0;          s_g_q <= '0;    s_b_q <= '0;
      hs_dly_q <= 1'b0;     vs_dly_q <= 1'b0; de_dly_q <= 1'b0;
      h_cnt_q <= '0;        de_len_q <= '0; v_line_q <= '0;  act_lines_q <= '0;
      meas_h_total_q <= '0; meas_h_active_q <= '0;
      x_cnt_q <= '0;        y_cnt_q <= '0;
      o_hs_q <= 1'b0;       o_vs_q <= 1'b0; o_de_q <= 1'b0;
      o_r_q <= '0;          o_g_q <= '0;    o_b_q <= '0;
      o_x_q <= '0;          o_y_q <= '0;    o_sof_q <= 1'b0; o_eol_q <= 1'b0;
    end else begin
      state_q <= state_d;   match_q <= match_d; ref_valid_q <= ref_valid_d;
      ref_q <= ref_d;       pub_q <= pub_d; locked_q <= locked_d; err_q <= err_d;
      s_hs_q <= s_hs_d;     s_vs_q <= s_vs_d; s_de_q <= s_de_d;
      s_r_q <= s_r_d;       s_g_q <= s_g_d; s_b_q <= s_b_d;
      hs_dly_q <= hs_dly_d; vs_dly_q <= vs_dly_d; de_dly_q <= de_dly_d;
      h_cnt_q <= h_cnt_d;   de_len_q <= de_len_d; v_line_q <= v_line_d; act_lines_q <= act_lines_d;
      meas_h_total_q <= meas_h_total_d; meas_h_active_q <= meas_h_active_d;
      x_cnt_q <= x_cnt_d;   y_cnt_q <= y_cnt_d;
      o_hs_q <= o_hs_d;     o_vs_q <= o_vs_d; o_de_q <= o_de_d;
      o_r_q <= o_r_d;       o_g_q <= o_g_d; o_b_q <= o_b_d;
      o_x_q <= o_x_d;       o_y_q <= o_y_d; o_sof_q <= o_sof_d; o_eol_q <= o_eol_d;
    end
  end

  assign o_hs       = o_hs_q;
  assign o_vs       = o_vs_q;
  assign o_de       = o_de_q;
  assign o_r        = o_r_q;
  assign o_g        = o_g_q;
  assign o_b        = o_b_q;
  assign o_x        = o_x_q;
  assign o_y        = o_y_q;
  assign o_sof      = o_sof_q;
  assign o_eol      = o_eol_q;
  assign o_h_total  = pub_q[4*CNT_W-1:3*CNT_W];
  assign o_h_active = pub_q[3*CNT_W-1:2*CNT_W];
  assign o_v_total  = pub_q[2*CNT_W-1:CNT_W];
  assign o_v_active = pub_q[CNT_W-1:0];
  assign o_locked   = locked_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_video_timing_detect.sv
// Scoreboard bench for video_timing_detect: a positive-sync and an inverted-sync instance
// are fed the same small-format generator stream and checked against one expected queue.
module tb_video_timing_detect;

  typedef logic [63:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0;
  logic n_hs, n_vs;
  assign n_hs = ~i_hs;
  assign n_vs = ~i_vs;

  logic a_hs, a_vs, a_de, a_sof, a_eol, a_locked, a_err;
  logic [7:0] a_r, a_g, a_b;
  logic [15:0] a_x, a_y, a_ht, a_ha, a_vt, a_va;
  logic b_hs, b_vs, b_de, b_sof, b_eol, b_locked, b_err;
  logic [7:0] b_r, b_g, b_b;
  logic [15:0] b_x, b_y, b_ht, b_ha, b_vt, b_va;

  video_timing_detect #(.HS_POLORY(1'b1), .VS_POLORY(1'b1), .CNT_W(16), .LOCK_FRAMES(2)) u_pos (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_r(a_r), .o_g(a_g), .o_b(a_b),
    .o_x(a_x), .o_y(a_y), .o_sof(a_sof), .o_eol(a_eol),
    .o_h_total(a_ht), .o_h_active(a_ha), .o_v_total(a_vt), .o_v_active(a_va),
    .o_locked(a_locked), .o_err(a_err));

  video_timing_detect #(.HS_POLORY(1'b0), .VS_POLORY(1'b0), .CNT_W(16), .LOCK_FRAMES(2)) u_neg (
    .clk(clk), .rst_n(rst_n), .i_hs(n_hs), .i_vs(n_vs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_r(b_r), .o_g(b_g), .o_b(b_b),
    .o_x(b_x), .o_y(b_y), .o_sof(b_sof), .o_eol(b_eol),
    .o_h_total(b_ht), .o_h_active(b_ha), .o_v_total(b_vt), .o_v_active(b_va),
    .o_locked(b_locked), .o_err(b_err));

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  word_t sb_q[$];

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic word_t strm_a();
    return {1'b0, a_hs, a_vs, a_de, a_r, a_g, a_b, a_de ? a_x : 16'h0, a_de ? a_y : 16'h0,
            a_sof, a_eol, a_locked, a_err};
  endfunction

  function automatic word_t strm_b();
    return {1'b0, b_hs, b_vs, b_de, b_r, b_g, b_b, b_de ? b_x : 16'h0, b_de ? b_y : 16'h0,
            b_sof, b_eol, b_locked, b_err};
  endfunction

  task automatic check_fmt(input string tag, input logic lock, input int ht, input int ha,
                           input int vt, input int va);
    word_t exp;
    exp = {16'(ht), 16'(ha), 16'(vt), 16'(va)};
    check({tag, "_fmt_pos"}, {a_ht, a_ha, a_vt, a_va}, exp);
    check({tag, "_fmt_neg"}, {b_ht, b_ha, b_vt, b_va}, exp);
    check({tag, "_lock_pos"}, word_t'(a_locked), word_t'(lock));
    check({tag, "_lock_neg"}, word_t'(b_locked), word_t'(lock));
  endtask

  // Format: H sync 4 / bp 4 / active act / fp 4, V sync 2 / bp 2 / active 6 / fp 2.
  task automatic drive_frame(input int act, input bit de_en, input bit lock, input bit err,
                             input int pub_act, input int max_cyc);
    int htot;
    int n;
    htot = 12 + act;
    n = 0;
    for (int l = 0; l < 12; l++) begin
      for (int h = 0; h < htot; h++) begin
        bit hs, vs, de, sof, eol, e_err;
        logic [15:0] x, y;
        if (n == max_cyc) return;
        n++;
        hs = (h < 4);
        vs = (l < 2);
        de = de_en && l >= 4 && l < 10 && h >= 8 && h < 8 + act;
        x = de ? 16'(h - 8) : 16'h0;
        y = de ? 16'(l - 4) : 16'h0;
        sof = de && x == 0 && y == 0;
        eol = lock && de && (int'(x) == pub_act - 1);
        e_err = err && l == 0 && h == 0;
        @(negedge clk);
        if (sb_q.size() >= 2) begin
          word_t exp;
          exp = sb_q.pop_front();
          check("strm_pos", strm_a(), exp);
          check("strm_neg", strm_b(), exp);
        end
        i_hs = hs;
        i_vs = vs;
        i_de = de;
        i_r = cyc[7:0];
        i_g = cyc[15:8];
        i_b = 8'(h ^ (l << 4));
        cyc++;
        sb_q.push_back({1'b0, hs, vs, de, i_r, i_g, i_b, x, y, sof, eol, lock, e_err});
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pos"}, {a_ht, a_ha, a_vt, a_va}, 64'h0);
    check({tag, "_neg"}, {b_ht, b_ha, b_vt, b_va}, 64'h0);
    check({tag, "_strm_pos"}, strm_a() | word_t'({a_x, a_y}), 64'h0);
    check({tag, "_strm_neg"}, strm_b() | word_t'({b_x, b_y}), 64'h0);
  endtask

  localparam int NOLIM = 1 << 30;

  initial begin
    repeat (2) @(negedge clk);
    check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 6; f++) drive_frame(16, 1'b1, f >= 3, 1'b0, 16, NOLIM);
    check_fmt("lock16", 1'b1, 28, 16, 12, 6);

    drive_frame(12, 1'b1, 1'b1, 1'b0, 16, NOLIM);
    drive_frame(12, 1'b1, 1'b0, 1'b1, 16, NOLIM);
    drive_frame(12, 1'b1, 1'b0, 1'b0, 16, NOLIM);
    check_fmt("held16", 1'b0, 28, 16, 12, 6);
    drive_frame(12, 1'b1, 1'b1, 1'b0, 12, NOLIM);
    check_fmt("lock12", 1'b1, 24, 12, 12, 6);
    drive_frame(12, 1'b1, 1'b1, 1'b0, 12, 150);

    @(negedge clk);
    rst_n = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_r = '0; i_g = '0; i_b = '0;
    #1;
    check_zero("rst_mid");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 5; f++) drive_frame(16, 1'b1, f >= 3, 1'b0, 16, NOLIM);
    check_fmt("relock", 1'b1, 28, 16, 12, 6);

    drive_frame(16, 1'b0, 1'b1, 1'b0, 16, NOLIM);
    drive_frame(16, 1'b0, 1'b0, 1'b1, 16, NOLIM);
    drive_frame(16, 1'b0, 1'b0, 1'b0, 16, NOLIM);
    drive_frame(16, 1'b0, 1'b0, 1'b0, 16, NOLIM);
    check_fmt("no_de", 1'b0, 28, 16, 12, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
